// File: rtl/seg7_display_scan_if.sv
// Purpose: bundles the BCD clock/calendar digits, control pulses and display drive of seg7_display_scan.
// Latency: none (wiring only).
// Backpressure: none; the master drives level digits and single-cycle pulses, the slave drives the display.
// Signals:
//   tick_1Hz, mode_btn           one-cycle pulses from the clock top / debouncer
//   sec                          seconds, binary 0-59
//   hr_*, min_*, d_*, m_*, y_*   BCD digits
//   an, seg, dp                  active-low anode, segment {g,f,e,d,c,b,a} and decimal-point drive
//   mode                         00 TIME, 01 DATE, 10 AUTO
`timescale 1ns/1ps
interface seg7_display_scan_if;
  logic       tick_1Hz;
  logic       mode_btn;
  logic [5:0] sec;
  logic [3:0] hr_10s;
  logic [3:0] hr_1s;
  logic [3:0] min_10s;
  logic [3:0] min_1s;
  logic [3:0] d_10s;
  logic [3:0] d_1s;
  logic [3:0] m_10s;
  logic [3:0] m_1s;
  logic [3:0] y_10s;
  logic [3:0] y_1s;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] mode;

  // Clock/calendar side: drives digits and pulses, observes the display.
  modport master (
    output tick_1Hz, mode_btn, sec,
    output hr_10s, hr_1s, min_10s, min_1s,
    output d_10s, d_1s, m_10s, m_1s, y_10s, y_1s,
    input  an, seg, dp, mode
  );

  // Display scanner side.
  modport slave (
    input  tick_1Hz, mode_btn, sec,
    input  hr_10s, hr_1s, min_10s, min_1s,
    input  d_10s, d_1s, m_10s, m_1s, y_10s, y_1s,
    output an, seg, dp, mode
  );
endinterface

// File: rtl/seg7_display_scan.sv
// Purpose: time-multiplexes TIME/DATE BCD digits onto an 8-digit common-anode 7-segment display.
// Latency: an/seg/dp follow the digit index by 1 cycle; inputs are snapshotted once per 8-slot frame.
// Backpressure: none; inputs are sampled levels/pulses and the display is free-running.
// Ports:
//   clk_100MHz  system clock
//   reset       synchronous, active-high
//   bus         seg7_display_scan_if.slave: digits, tick_1Hz, mode_btn in; an, seg, dp, mode out
// Optional feature macro: GHOST_BLANK_EN -- when defined, anodes are held off for the first
// BLANK_CYC cycles of every slot to suppress ghosting between neighbouring digits.
`timescale 1ns/1ps
module seg7_display_scan #(
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 1000,
  parameter int ALT_SEC    = 3,
  parameter int BLANK_CYC  = 2
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  seg7_display_scan_if.slave   bus
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (ALT_SEC > 1) ? $clog2(ALT_SEC) : 1;

  localparam logic [PW-1:0] PS_MAX  = PW'(DIV - 1);
  localparam logic [AW-1:0] ALT_MAX = AW'(ALT_SEC - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    MODE_TIME = 2'b00,
    MODE_DATE = 2'b01,
    MODE_AUTO = 2'b10
  } mode_e;

  // One frame's worth of digits, frozen at the 7 -> 0 wrap.
  typedef struct packed {
    logic [5:0] sec;
    logic [3:0] hr_10s;
    logic [3:0] hr_1s;
    logic [3:0] min_10s;
    logic [3:0] min_1s;
    logic [3:0] d_10s;
    logic [3:0] d_1s;
    logic [3:0] m_10s;
    logic [3:0] m_1s;
    logic [3:0] y_10s;
    logic [3:0] y_1s;
  } snap_t;

  // ---------------------------------------------------------------------------
  // Segment decoder: out-of-range nibbles show a dash rather than garbage.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic          active;     // low until the first slot after reset has elapsed
  logic          view_date;  // view latched at slot start so a slot is never glitched
  snap_t         snap;
  snap_t         snap_in;

  mode_e         state, state_nxt;
  logic [AW-1:0] alt_cnt, alt_nxt;
  logic          show_date, show_nxt;

  logic [7:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  logic          slot_end;
  logic          ghost_blank;

  assign slot_end = (prescaler == PS_MAX);

  assign snap_in = '{
    sec:     bus.sec,
    hr_10s:  bus.hr_10s,
    hr_1s:   bus.hr_1s,
    min_10s: bus.min_10s,
    min_1s:  bus.min_1s,
    d_10s:   bus.d_10s,
    d_1s:    bus.d_1s,
    m_10s:   bus.m_10s,
    m_1s:    bus.m_1s,
    y_10s:   bus.y_10s,
    y_1s:    bus.y_1s
  };

  // ---------------------------------------------------------------------------
  // Slot timing, digit index and frame snapshot.
  // The first slot_end after reset only arms the scan, so digit 0 gets a full
  // slot before any later digit is shown.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= 3'd0;
      active    <= 1'b0;
      view_date <= 1'b0;
      snap      <= '0;
    end else if (slot_end) begin
      prescaler <= '0;
      view_date <= (state == MODE_DATE) || ((state == MODE_AUTO) && show_date);
      if (!active) begin
        active <= 1'b1;
      end else begin
        idx <= idx + 3'd1;
        if (idx == 3'd7) begin
          snap <= snap_in;
        end
      end
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM with AUTO alternation counter.
  // A mode_btn pulse outranks a coincident tick; outside AUTO the counter and
  // show_date are held at zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state     <= MODE_TIME;
      alt_cnt   <= '0;
      show_date <= 1'b0;
    end else begin
      state     <= state_nxt;
      alt_cnt   <= alt_nxt;
      show_date <= show_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    alt_nxt   = '0;
    show_nxt  = 1'b0;
    case (state)
      MODE_TIME: begin
        if (bus.mode_btn) state_nxt = MODE_DATE;
      end
      MODE_DATE: begin
        if (bus.mode_btn) state_nxt = MODE_AUTO;
      end
      MODE_AUTO: begin
        alt_nxt  = alt_cnt;
        show_nxt = show_date;
        if (bus.mode_btn) begin
          state_nxt = MODE_TIME;
          alt_nxt   = '0;
          show_nxt  = 1'b0;
        end else if (bus.tick_1Hz) begin
          if (alt_cnt == ALT_MAX) begin
            alt_nxt  = '0;
            show_nxt = ~show_date;
          end else begin
            alt_nxt = alt_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = MODE_TIME;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Seconds to two digits by compare/subtract (no divider).
  // ---------------------------------------------------------------------------
  logic       sec_bad;
  logic [3:0] sec_t;
  logic [3:0] sec_o;

  always_comb begin
    sec_bad = (snap.sec > 6'd59);
    sec_t   = 4'd0;
    sec_o   = 4'(snap.sec);
    if (snap.sec >= 6'd50) begin
      sec_t = 4'd5;
      sec_o = 4'(snap.sec - 6'd50);
    end else if (snap.sec >= 6'd40) begin
      sec_t = 4'd4;
      sec_o = 4'(snap.sec - 6'd40);
    end else if (snap.sec >= 6'd30) begin
      sec_t = 4'd3;
      sec_o = 4'(snap.sec - 6'd30);
    end else if (snap.sec >= 6'd20) begin
      sec_t = 4'd2;
      sec_o = 4'(snap.sec - 6'd20);
    end else if (snap.sec >= 6'd10) begin
      sec_t = 4'd1;
      sec_o = 4'(snap.sec - 6'd10);
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection for the current index.
  // ---------------------------------------------------------------------------
  logic [3:0] sel_nib;
  logic       sel_blank;
  logic       sel_dash;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [7:0] an_nxt;

  always_comb begin
    sel_nib   = 4'd0;
    sel_blank = 1'b0;
    sel_dash  = 1'b0;
    case (idx)
      3'd5: sel_nib = view_date ? snap.d_10s : snap.hr_10s;
      3'd4: sel_nib = view_date ? snap.d_1s  : snap.hr_1s;
      3'd3: sel_nib = view_date ? snap.m_10s : snap.min_10s;
      3'd2: sel_nib = view_date ? snap.m_1s  : snap.min_1s;
      3'd1: begin
        if (view_date)    sel_nib  = snap.y_10s;
        else if (sec_bad) sel_dash = 1'b1;
        else              sel_nib  = sec_t;
      end
      3'd0: begin
        if (view_date)    sel_nib  = snap.y_1s;
        else if (sec_bad) sel_dash = 1'b1;
        else              sel_nib  = sec_o;
      end
      default: sel_blank = 1'b1;  // d7, d6
    endcase
  end

  assign seg_nxt = sel_blank ? SEG_BLANK : (sel_dash ? SEG_DASH : bcd_to_seg(sel_nib));
  assign dp_nxt  = !((idx == 3'd4) || (idx == 3'd2));
  assign an_nxt  = ~(8'b1 << idx);

`ifdef GHOST_BLANK_EN
  localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
  // prescaler restarts with each new idx, so this covers the slot's opening cycles.
  assign ghost_blank = (prescaler < BLANK_LIM);
`else
  localparam int UNUSED_BLANK_CYC = BLANK_CYC;
  assign ghost_blank = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Registered display drive.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      an_r  <= 8'hFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else if (!active) begin
      an_r  <= 8'hFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= ghost_blank ? 8'hFF : an_nxt;
      seg_r <= seg_nxt;
      dp_r  <= dp_nxt;
    end
  end

  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = dp_r;
  assign bus.mode = state;

endmodule

// File: tb/tb_seg7_display_scan.sv
// Purpose: scoreboard bench for seg7_display_scan with a slot-level reference model.
// Latency: expected slot pushed at slot start, compared when the DUT lights that slot.
// Backpressure: none.
`timescale 1ns/1ps
module tb_seg7_display_scan;

  localparam int CLK_HZ     = 80;
  localparam int REFRESH_HZ = 10;
  localparam int ALT_SEC    = 3;
  localparam int BLANK_CYC  = 2;
  localparam int DIV        = CLK_HZ / REFRESH_HZ;
`ifdef GHOST_BLANK_EN
  localparam int LEAD = BLANK_CYC;
`else
  localparam int LEAD = 0;
`endif

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;
  always #5 clk_100MHz = ~clk_100MHz;

  seg7_display_scan_if bus();

  seg7_display_scan #(
    .CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .ALT_SEC(ALT_SEC), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;
  disp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // ---------------- reference model ----------------
  int m_cyc, m_mode, m_alt, m_slot, m_idx;
  bit m_show, m_view;
  int snap_sec;
  int snap_time[4];  // hr_10s, hr_1s, min_10s, min_1s
  int snap_date[6];  // d_10s, d_1s, m_10s, m_1s, y_10s, y_1s

  function automatic logic [6:0] exp_seg(input int idx, input bit date);
    if (idx >= 6) return 7'b1111111;
    if (date) return glyph(snap_date[5-idx]);
    if (idx >= 2) return glyph(snap_time[5-idx]);
    if (snap_sec > 59) return 7'b0111111;
    return glyph(idx == 1 ? snap_sec / 10 : snap_sec % 10);
  endfunction

  always @(posedge clk_100MHz) begin
    if (reset) begin
      m_cyc = 0; m_mode = 0; m_alt = 0; m_show = 0; snap_sec = 0;
      foreach (snap_time[i]) snap_time[i] = 0;
      foreach (snap_date[i]) snap_date[i] = 0;
      exp_q.delete();
    end else begin
      m_cyc++;
      if (m_cyc >= DIV && m_cyc % DIV == 0) begin
        m_slot = (m_cyc - DIV) / DIV;
        m_idx  = m_slot % 8;
        if (m_idx == 0 && m_slot > 0) begin
          snap_sec = bus.sec;
          snap_time[0] = bus.hr_10s;  snap_time[1] = bus.hr_1s;
          snap_time[2] = bus.min_10s; snap_time[3] = bus.min_1s;
          snap_date[0] = bus.d_10s; snap_date[1] = bus.d_1s;
          snap_date[2] = bus.m_10s; snap_date[3] = bus.m_1s;
          snap_date[4] = bus.y_10s; snap_date[5] = bus.y_1s;
        end
        m_view = (m_mode == 1) || (m_mode == 2 && m_show);
        exp_q.push_back('{an: ~(8'd1 << m_idx), seg: exp_seg(m_idx, m_view),
                          dp: !(m_idx == 4 || m_idx == 2)});
      end
      if (bus.mode_btn) begin
        m_mode = (m_mode + 1) % 3;
        m_alt  = 0;
        m_show = 0;
      end else if (m_mode == 2 && bus.tick_1Hz) begin
        m_alt++;
        if (m_alt == ALT_SEC) begin
          m_alt  = 0;
          m_show = !m_show;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] prev_an = 8'hFF;
  int lit_len = 0;
  disp_t got;

  always @(negedge clk_100MHz) begin
    if (reset) begin
      prev_an = 8'hFF;
      lit_len = 0;
    end else begin
      check("mode", 32'(bus.mode), 32'(m_mode));
      if (bus.an != 8'hFF) check("an_onehot", 32'($countones(~bus.an)), 32'd1);
      if (bus.an != prev_an) begin
        if (prev_an != 8'hFF) check("lit_len", 32'(lit_len), 32'(DIV - LEAD));
        if (bus.an != 8'hFF) begin
          if (exp_q.size() == 0) begin
            check("unexpected_slot", 32'(bus.an), 32'hFF);
          end else begin
            got = exp_q.pop_front();
            check("slot_an",  32'(bus.an),  32'(got.an));
            check("slot_seg", 32'(bus.seg), 32'(got.seg));
            check("slot_dp",  32'(bus.dp),  32'(got.dp));
          end
          lit_len = 1;
        end
        prev_an = bus.an;
      end else if (bus.an != 8'hFF) begin
        lit_len++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic pulse(input bit btn, input bit tk);
    bus.mode_btn = btn;
    bus.tick_1Hz = tk;
    @(negedge clk_100MHz);
    bus.mode_btn = 1'b0;
    bus.tick_1Hz = 1'b0;
  endtask

  task automatic set_time(input int h10, input int h1, input int m10, input int m1, input int s);
    bus.hr_10s = 4'(h10); bus.hr_1s = 4'(h1);
    bus.min_10s = 4'(m10); bus.min_1s = 4'(m1);
    bus.sec = 6'(s);
  endtask

  task automatic set_date(input int a, input int b, input int c, input int d, input int e, input int f);
    bus.d_10s = 4'(a); bus.d_1s = 4'(b);
    bus.m_10s = 4'(c); bus.m_1s = 4'(d);
    bus.y_10s = 4'(e); bus.y_1s = 4'(f);
  endtask

  function automatic int rnd_nib();
    return ($urandom % 8 == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
  endfunction

  task automatic reset_and_release();
    int n;
    reset = 1'b1;
    wait_cyc(3);
    check("rst_an",   32'(bus.an),   32'hFF);
    check("rst_seg",  32'(bus.seg),  32'h7F);
    check("rst_dp",   32'(bus.dp),   32'd1);
    check("rst_mode", 32'(bus.mode), 32'd0);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (bus.an == 8'hFF && n < 40);
    check("first_lit_delay", 32'(n), 32'(DIV + 1 + LEAD));
    check("first_lit_an", 32'(bus.an), 32'hFE);
  endtask

  task automatic wait_an(input logic [7:0] target);
    int n;
    n = 0;
    while (bus.an != target && n < 200) begin
      @(negedge clk_100MHz);
      n++;
    end
    if (n >= 200) check("wait_an_timeout", 32'(bus.an), 32'(target));
  endtask

  initial begin
    bus.mode_btn = 1'b0;
    bus.tick_1Hz = 1'b0;
    set_time(2, 3, 5, 9, 47);
    set_date(1, 5, 0, 8, 2, 4);
    @(negedge clk_100MHz);
    reset_and_release();

    // Two frames: the first shows the reset snapshot, the second the inputs.
    wait_cyc(2 * 8 * DIV);

    // Change inputs mid-frame; the model expects them only after the wrap.
    wait_an(8'b1111_0111);
    set_time(1, 7, 4, 2, 8);
    wait_cyc(2 * 8 * DIV);

    // TIME -> DATE -> AUTO, then alternate views on ticks.
    pulse(1'b1, 1'b0);
    check("mode_date", 32'(bus.mode), 32'd1);
    wait_cyc(8 * DIV);
    pulse(1'b1, 1'b0);
    check("mode_auto", 32'(bus.mode), 32'd2);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(10);
      pulse(1'b0, 1'b1);
    end
    wait_cyc(2 * 8 * DIV);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(10);
      pulse(1'b0, 1'b1);
    end
    wait_cyc(8 * DIV);
    pulse(1'b1, 1'b1);
    check("mode_btn_tick", 32'(bus.mode), 32'd0);
    wait_cyc(8 * DIV);

    // Out-of-range values.
    set_time(12, 3, 5, 9, 63);
    wait_cyc(2 * 8 * DIV);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("mode_wrap", 32'(bus.mode), 32'd0);
    wait_cyc(8 * DIV);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 20 == 0) begin
        set_time(rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib(), int'($urandom_range(0, 63)));
        set_date(rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib());
      end
      bus.mode_btn = ($urandom % 60 == 0);
      bus.tick_1Hz = ($urandom % 12 == 0);
      @(negedge clk_100MHz);
    end
    bus.mode_btn = 1'b0;
    bus.tick_1Hz = 1'b0;

    // Reset in the middle of a frame.
    wait_cyc(int'($urandom_range(3, 50)));
    reset_and_release();
    wait_cyc(2 * 8 * DIV);

    // Every pushed slot must have been seen.
    wait_an(8'hFE);
    wait_cyc(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_display_scan.md
Name: seg7_display_scan

Overview:
- Downstream consumer of the clock/calendar top's BCD digits.
- Time-multiplexes them onto an 8-digit common-anode 7-segment display.
- Mode FSM selects among time view, date view, and auto-alternating view; a single-cycle `mode_btn` pulse cycles the mode.
- All outputs are registered; the input snapshot is taken once per scan frame, so the display never shows a mix of old and new digits within a frame.

Parameters:
- CLK_HZ, 100000000, input clock frequency
- REFRESH_HZ, 1000, digit-slot rate; slot length DIV = CLK_HZ/REFRESH_HZ cycles (DIV ≥ 4)
- ALT_SEC, 3, tick_1Hz pulses per view in AUTO mode (≥ 1)
- BLANK_CYC, 2, anode-off cycles at slot start (GHOST_BLANK_EN only; < DIV)

Ports:
- clk_100MHz input 1 system clock
- reset input 1 synchronous, active-high
- tick_1Hz input 1 one-cycle pulse per second
- mode_btn input 1 one-cycle pulse (already debounced); cycles mode
- sec input 6 seconds, binary 0-59
- hr_10s, hr_1s, min_10s, min_1s input 4 each, BCD time digits
- d_10s, d_1s, m_10s, m_1s, y_10s, y_1s input 4 each, BCD date digits
- an output 8 anode enables, active-low, bit i = digit i (0 = rightmost)
- seg output 7 {g,f,e,d,c,b,a}, active-low
- dp output 1 decimal point, active-low
- mode output 2 00 = TIME, 01 = DATE, 10 = AUTO

Behaviour:
- Reset (synchronous, active-high) values:
  - an = 8'hFF, seg = 7'h7F, dp = 1, mode = 00
  - prescaler = 0, digit index idx = 0, alt counter = 0, show_date = 0, snapshot = all zero
- Prescaler:
  - counts 0..DIV-1; wraps to 0 and asserts slot_end for one cycle.
  - On slot_end, idx increments modulo 8 (7 → 0).
- Snapshot:
  - On the cycle idx goes 7 → 0, all digit inputs and `sec` are registered.
  - All slots of that frame display the snapshot only.
- Seconds conversion: sec_t = sec/10, sec_o = sec%10, done by compare/subtract; no divider IP.
- Digit map, TIME view:
  - d7 = d6 = blank; d5 = hr_10s, d4 = hr_1s, d3 = min_10s, d2 = min_1s, d1 = sec_t, d0 = sec_o
  - dp lit on d4 and d2.
- Digit map, DATE view: same positions with d_10s, d_1s, m_10s, m_1s, y_10s, y_1s; dp lit on d4 and d2.
- Decoder:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - BCD nibble > 9 → dash 0111111; sec > 59 → dash on both d1 and d0; blank = 1111111.
- Output timing: an/seg/dp update exactly 1 cycle after idx changes. an has exactly one zero bit (digit idx) except during reset.
- Mode FSM:
  - mode_btn: TIME → DATE → AUTO → TIME.
  - Entering AUTO sets alt counter = 0 and show_date = 0.
- AUTO mode:
  - Each tick_1Hz increments the alt counter.
  - When the counter reaches ALT_SEC-1 and a tick arrives, it clears and show_date toggles.
  - View = DATE if show_date, else TIME.
- Mode changes take effect at the next slot; the current slot is not glitched.
- Simultaneous events:
  - mode_btn with tick_1Hz in the same cycle: mode change wins and the tick is ignored for the alt counter.
  - tick_1Hz outside AUTO: ignored, counter held at 0.
- Reset mid-frame: everything returns to reset values on the next edge; the scan restarts at idx 0 after DIV cycles.

Optional Feature:
- Macro: GHOST_BLANK_EN.
- When defined: an forced to 8'hFF for the first BLANK_CYC cycles of every slot (prescaler < BLANK_CYC); seg/dp still update on schedule. This removes ghosting between digits.
- When undefined: an is active for the whole slot and BLANK_CYC is unused.

Test Plan:
- Bench params CLK_HZ = 80, REFRESH_HZ = 10 (DIV = 8). Reset, then release:
  - an = FF and seg = 7F during reset.
  - First an = 11111110 appears 9 cycles after release (8-cycle slot + 1 output cycle) and stays 8 cycles.
- TIME, hr = 2,3 min = 5,9 sec = 47: a full frame shows d5..d0 = 2,3,5,9,4,7 with correct codes, dp low only on d4/d2, and d7/d6 blank.
- Change inputs while idx = 3: displayed digits stay unchanged until idx wraps 7 → 0, then reflect the new values.
- mode_btn ×2 (to AUTO), ALT_SEC = 3: three tick_1Hz give DATE digits (d = 1,5 m = 0,8 y = 2,4 → 1,5,0,8,2,4); three more return to TIME. A mode_btn coincident with a tick goes to TIME with no toggle.
- sec = 63 → d1/d0 dash; hr_10s = 4'hC → d5 dash; mode_btn ×3 returns mode to 00.
- With GHOST_BLANK_EN, BLANK_CYC = 2: an = FF for 2 cycles at the start of each slot, then the single low bit for 6 cycles.
